// File: rtl/cmp_pair_sequencer_pkg.sv
// Shared result codes and sequencer state encoding for the sign-magnitude
// comparator pair sequencer.
package cmp_pkg;

  typedef logic [1:0] cmp_code_t;

  localparam cmp_code_t CMP_A_GT = 2'b10;
  localparam cmp_code_t CMP_B_GT = 2'b01;
  localparam cmp_code_t CMP_EQ   = 2'b00;
  localparam cmp_code_t CMP_INV  = 2'b11;

  typedef enum logic [1:0] {
    S_GET_A   = 2'd0,
    S_GET_B   = 2'd1,
    S_SETTLE  = 2'd2,
    S_PRESENT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/cmp_pair_sequencer_if.sv
// Byte input, comparator, result and tally signals of the pair sequencer.
// master = sequencer side, slave = surrounding environment.
interface cmp_pair_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) ();
  import cmp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] cmp_a;
  logic [DATA_W-1:0] cmp_b;
  cmp_code_t         cmp_res;
  logic              out_valid;
  logic              out_ready;
  cmp_code_t         out_res;
  logic [CNT_W-1:0]  cnt_a_gt;
  logic [CNT_W-1:0]  cnt_b_gt;
  logic [CNT_W-1:0]  cnt_eq;
  logic              err;
  logic              clear;

  modport master (
    input  in_valid, in_data, cmp_res, out_ready, clear,
    output in_ready, cmp_a, cmp_b, out_valid, out_res,
           cnt_a_gt, cnt_b_gt, cnt_eq, err
  );

  modport slave (
    output in_valid, in_data, cmp_res, out_ready, clear,
    input  in_ready, cmp_a, cmp_b, out_valid, out_res,
           cnt_a_gt, cnt_b_gt, cnt_eq, err
  );

endinterface

// File: rtl/cmp_pair_sequencer_tally.sv
// Saturating up-counter for one comparison outcome; clear beats increment.
module cmp_tally_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cmp_pair_sequencer.sv
// Pairs incoming bytes into A/B operands, holds them on the comparator for a
// settle window, samples the result once and presents it with per-outcome tallies.
module cmp_pair_sequencer #(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  cmp_pair_sequencer_if.master bus
);
  import cmp_pkg::*;

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  seq_state_t        state_q, state_d;
  logic [DATA_W-1:0] cmp_a_q, cmp_a_d;
  logic [DATA_W-1:0] cmp_b_q, cmp_b_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  cmp_code_t         out_res_q, out_res_d;
  logic              err_q, err_d;
  logic              in_ready_c;
  logic              out_valid_c;
  logic              sample_c;

  logic [2:0]        inc_vec;
  logic [CNT_W-1:0]  cnt_vec [3];

  always_comb begin
    state_d     = state_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    settle_d    = settle_q;
    out_res_d   = out_res_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    sample_c    = 1'b0;
    unique case (state_q)
      S_GET_A: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          cmp_a_d = bus.in_data;
          state_d = S_GET_B;
        end
      end
      S_GET_B: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          cmp_b_d  = bus.in_data;
          settle_d = SET_W'(SETTLE_CYC - 1);
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // cmp_res is only looked at on the last settle edge
        if (settle_q == '0) begin
          sample_c  = 1'b1;
          out_res_d = bus.cmp_res;
          state_d   = S_PRESENT;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      S_PRESENT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = S_GET_A;
        end
      end
      default: state_d = S_GET_A;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (bus.clear) begin
      err_d = 1'b0;
    end else if (sample_c && (bus.cmp_res == CMP_INV)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_GET_A;
      cmp_a_q   <= '0;
      cmp_b_q   <= '0;
      settle_q  <= '0;
      out_res_q <= CMP_EQ;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmp_a_q   <= cmp_a_d;
      cmp_b_q   <= cmp_b_d;
      settle_q  <= settle_d;
      out_res_q <= out_res_d;
      err_q     <= err_d;
    end
  end

  // Counter order: 0 = A>B, 1 = B>A, 2 = equal
  assign inc_vec[0] = sample_c && (bus.cmp_res == CMP_A_GT);
  assign inc_vec[1] = sample_c && (bus.cmp_res == CMP_B_GT);
  assign inc_vec[2] = sample_c && (bus.cmp_res == CMP_EQ);

  for (genvar gi = 0; gi < 3; gi++) begin : g_tally
    cmp_tally_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc_i(inc_vec[gi]),
      .clr_i(bus.clear),
      .cnt_o(cnt_vec[gi])
    );
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.cmp_a     = cmp_a_q;
  assign bus.cmp_b     = cmp_b_q;
  assign bus.out_res   = out_res_q;
  assign bus.err       = err_q;
  assign bus.cnt_a_gt  = cnt_vec[0];
  assign bus.cnt_b_gt  = cnt_vec[1];
  assign bus.cnt_eq    = cnt_vec[2];

endmodule

// File: tb/tb_cmp_pair_sequencer.sv
// Bench for cmp_pair_sequencer: three instances (default, CNT_W=2, SETTLE_CYC=3)
// each driven by a sign-magnitude comparator model with an override for forced codes.
module tb_cmp_pair_sequencer;

  logic        clk;
  logic [2:0]  rst_n_t, in_valid_t, out_ready_t, clear_t, frc_en;
  logic [7:0]  in_data_t [3];
  logic [1:0]  frc_code  [3];
  logic [2:0]  in_ready_w, out_valid_w, err_w;
  logic [7:0]  a_w [3];
  logic [7:0]  b_w [3];
  logic [1:0]  res_w [3];
  logic [15:0] cga [3];
  logic [15:0] cgb [3];
  logic [15:0] ceq [3];

  int n_cmp = 0;
  int n_bad = 0;
  int mc [3][3];
  int me [3];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] exp_res;
  } vec_t;
  vec_t vecs [10];

  // Comparator model: plain signed integers from sign-magnitude (-0 == +0)
  function automatic logic [1:0] ref_cmp(input logic [7:0] a, input logic [7:0] b);
    int va, vb;
    va = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
    vb = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
    if (va > vb) return 2'b10;
    if (vb > va) return 2'b01;
    return 2'b00;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int CW = (gi == 1) ? 2 : 16;
    localparam int SC = (gi == 2) ? 3 : 1;
    cmp_pair_sequencer_if #(.DATA_W(8), .CNT_W(CW)) bus ();
    assign bus.in_valid  = in_valid_t[gi];
    assign bus.in_data   = in_data_t[gi];
    assign bus.out_ready = out_ready_t[gi];
    assign bus.clear     = clear_t[gi];
    assign bus.cmp_res   = frc_en[gi] ? frc_code[gi] : ref_cmp(bus.cmp_a, bus.cmp_b);
    assign in_ready_w[gi]  = bus.in_ready;
    assign out_valid_w[gi] = bus.out_valid;
    assign err_w[gi]       = bus.err;
    assign a_w[gi]   = bus.cmp_a;
    assign b_w[gi]   = bus.cmp_b;
    assign res_w[gi] = bus.out_res;
    assign cga[gi]   = 16'(bus.cnt_a_gt);
    assign cgb[gi]   = 16'(bus.cnt_b_gt);
    assign ceq[gi]   = 16'(bus.cnt_eq);
    cmp_pair_sequencer #(
      .DATA_W(8), .CNT_W(CW), .SETTLE_CYC(SC)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n_t[gi]),
      .bus  (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear(input int d);
    for (int k = 0; k < 3; k++) mc[d][k] = 0;
    me[d] = 0;
  endtask

  task automatic tally(input int d, input logic [1:0] code, input int maxv);
    case (code)
      2'b10:   if (mc[d][0] < maxv) mc[d][0]++;
      2'b01:   if (mc[d][1] < maxv) mc[d][1]++;
      2'b00:   if (mc[d][2] < maxv) mc[d][2]++;
      default: me[d] = 1;
    endcase
  endtask

  task automatic check_cnt(input int d);
    check("cnt_a_gt", 32'(cga[d]), mc[d][0]);
    check("cnt_b_gt", 32'(cgb[d]), mc[d][1]);
    check("cnt_eq",   32'(ceq[d]), mc[d][2]);
    check("err",      32'(err_w[d]), me[d]);
  endtask

  // Call at a negedge; returns at the negedge after the accept edge
  task automatic push(input int d, input logic [7:0] v);
    int n;
    n = 0;
    in_valid_t[d] = 1'b1;
    in_data_t[d]  = v;
    #1;
    while (in_ready_w[d] !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("in_accept", 32'(in_ready_w[d]), 1);
    @(negedge clk);
    in_valid_t[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, input int exp_lat);
    int lat;
    lat = 0;
    #1;
    while (out_valid_w[d] !== 1'b1 && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    check("latency", lat, exp_lat);
  endtask

  task automatic pop(input int d);
    out_ready_t[d] = 1'b1;
    @(negedge clk);
    out_ready_t[d] = 1'b0;
  endtask

  task automatic pair(input int d, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] exp, input int lat, input int maxv);
    push(d, a);
    push(d, b);
    wait_valid(d, lat);
    check("out_res", 32'(res_w[d]), 32'(exp));
    check("cmp_a", 32'(a_w[d]), 32'(a));
    check("cmp_b", 32'(b_w[d]), 32'(b));
    tally(d, exp, maxv);
    check_cnt(d);
    $display("pair dut%0d A=%02h B=%02h res=%b cnt=%0d/%0d/%0d err=%b",
             d, a, b, res_w[d], cga[d], cgb[d], ceq[d], err_w[d]);
    pop(d);
  endtask

  logic [7:0]  bq [$];
  logic [15:0] pq [$];
  logic [15:0] pe;
  logic [7:0]  pa, pb;
  bit          pend;
  int          r;

  initial begin
    rst_n_t = '0; in_valid_t = '0; out_ready_t = '0; clear_t = '0; frc_en = '0;
    for (int i = 0; i < 3; i++) begin
      in_data_t[i] = '0;
      frc_code[i]  = 2'b00;
      model_clear(i);
    end
    vecs[0] = '{8'h05, 8'h03, 2'b10};
    vecs[1] = '{8'h03, 8'h05, 2'b01};
    vecs[2] = '{8'h7F, 8'h7F, 2'b00};
    vecs[3] = '{8'h80, 8'h00, 2'b00};
    vecs[4] = '{8'h81, 8'h01, 2'b01};
    vecs[5] = '{8'hFF, 8'h81, 2'b01};
    vecs[6] = '{8'h82, 8'h83, 2'b10};
    vecs[7] = '{8'h00, 8'h7F, 2'b01};
    vecs[8] = '{8'h85, 8'h05, 2'b01};
    vecs[9] = '{8'h7F, 8'hFF, 2'b10};

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready_w[0]), 1);
    check("rst_out_valid", 32'(out_valid_w[0]), 0);
    check("rst_cmp_a", 32'(a_w[0]), 0);
    check("rst_cmp_b", 32'(b_w[0]), 0);
    check("rst_out_res", 32'(res_w[0]), 0);
    check_cnt(0);
    @(negedge clk);
    rst_n_t = '1;

    // Table-driven pairs
    for (int i = 0; i < 10; i++) begin
      pair(0, vecs[i].a, vecs[i].b, vecs[i].exp_res, 1, 65535);
    end

    // Back-pressure: result held, input blocked, handshake edge accepts nothing
    push(0, 8'h10);
    push(0, 8'h90);
    wait_valid(0, 1);
    tally(0, 2'b10, 65535);
    in_valid_t[0] = 1'b1;
    in_data_t[0]  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("hold_out_valid", 32'(out_valid_w[0]), 1);
      check("hold_in_ready", 32'(in_ready_w[0]), 0);
      check("hold_cmp_a", 32'(a_w[0]), 32'h10);
      check("hold_cmp_b", 32'(b_w[0]), 32'h90);
      check("hold_out_res", 32'(res_w[0]), 32'h2);
    end
    $display("hold dut0 res=%b held 5 cycles", res_w[0]);
    out_ready_t[0] = 1'b1;
    @(negedge clk);
    out_ready_t[0] = 1'b0;
    #1;
    check("hs_edge_no_accept", 32'(a_w[0]), 32'h10);
    check("hs_out_valid", 32'(out_valid_w[0]), 0);
    check("hs_in_ready", 32'(in_ready_w[0]), 1);
    @(negedge clk); #1;
    check("post_hs_cmp_a", 32'(a_w[0]), 32'h55);
    push(0, 8'h55);
    wait_valid(0, 1);
    check("post_hs_res", 32'(res_w[0]), 0);
    tally(0, 2'b00, 65535);
    check_cnt(0);
    pop(0);

    // Invalid code, then clear
    frc_en[0] = 1'b1;
    frc_code[0] = 2'b11;
    pair(0, 8'h01, 8'h02, 2'b11, 1, 65535);
    frc_en[0] = 1'b0;
    clear_t[0] = 1'b1;
    @(negedge clk);
    clear_t[0] = 1'b0;
    model_clear(0);
    #1;
    check_cnt(0);
    $display("clear dut0 err=%b", err_w[0]);

    // Clear on the same edge as an equal sample with cnt_eq=4
    for (int i = 0; i < 4; i++) pair(0, 8'h22, 8'h22, 2'b00, 1, 65535);
    push(0, 8'h33);
    push(0, 8'h33);
    clear_t[0] = 1'b1;
    @(negedge clk);
    clear_t[0] = 1'b0;
    model_clear(0);
    #1;
    check("clr_race_valid", 32'(out_valid_w[0]), 1);
    check("clr_race_res", 32'(res_w[0]), 0);
    check_cnt(0);
    $display("clear+sample dut0 cnt_eq=%0d", ceq[0]);
    pop(0);

    // Reset while waiting for B
    push(0, 8'h81);
    #1;
    check("getb_cmp_a", 32'(a_w[0]), 32'h81);
    rst_n_t[0] = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready_w[0]), 1);
    check("mid_rst_out_valid", 32'(out_valid_w[0]), 0);
    check("mid_rst_cmp_a", 32'(a_w[0]), 0);
    model_clear(0);
    $display("reset dut0 in GET_B cmp_a=%02h", a_w[0]);
    @(negedge clk);
    rst_n_t[0] = 1'b1;
    pair(0, 8'h03, 8'h02, 2'b10, 1, 65535);

    // CNT_W=2 saturation
    for (int i = 0; i < 5; i++) pair(1, 8'h01, 8'h02, 2'b01, 1, 3);

    // SETTLE_CYC=3: forced 11 before the final settle edge must not be seen
    push(2, 8'h07);
    push(2, 8'h04);
    frc_en[2] = 1'b1;
    frc_code[2] = 2'b11;
    #1;
    check("settle_ov_0", 32'(out_valid_w[2]), 0);
    @(negedge clk); #1;
    check("settle_ov_1", 32'(out_valid_w[2]), 0);
    @(negedge clk);
    frc_en[2] = 1'b0;
    #1;
    check("settle_ov_2", 32'(out_valid_w[2]), 0);
    @(negedge clk); #1;
    check("settle_ov_3", 32'(out_valid_w[2]), 1);
    check("settle_res", 32'(res_w[2]), 32'h2);
    tally(2, 2'b10, 65535);
    check_cnt(2);
    frc_en[2] = 1'b1;
    @(negedge clk); #1;
    check("present_res_stable", 32'(res_w[2]), 32'h2);
    check_cnt(2);
    frc_en[2] = 1'b0;
    $display("settle dut2 res=%b err=%b", res_w[2], err_w[2]);
    pop(2);
    pair(2, 8'h84, 8'h02, 2'b01, 3, 65535);

    // Randomised traffic against a pair/queue model
    clear_t[0] = 1'b1;
    @(negedge clk);
    clear_t[0] = 1'b0;
    model_clear(0);
    pend = 1'b0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      if (c < 850) begin
        in_valid_t[0] = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 7);
        in_data_t[0] = (r == 0) ? 8'h00 : (r == 1) ? 8'h80 : 8'($urandom);
        out_ready_t[0] = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid_t[0] = 1'b0;
        out_ready_t[0] = 1'b1;
      end
      #1;
      if (pend) check("rnd_hold_valid", 32'(out_valid_w[0]), 1);
      if (in_valid_t[0] && in_ready_w[0]) begin
        bq.push_back(in_data_t[0]);
        if (bq.size() == 2) begin
          pa = bq.pop_front();
          pb = bq.pop_front();
          pq.push_back({pa, pb});
          tally(0, ref_cmp(pa, pb), 65535);
        end
      end
      if (out_valid_w[0] && out_ready_t[0]) begin
        if (pq.size() == 0) begin
          check("rnd_spurious_valid", 32'(out_valid_w[0]), 0);
        end else begin
          pe = pq.pop_front();
          check("rnd_out_res", 32'(res_w[0]), 32'(ref_cmp(pe[15:8], pe[7:0])));
          check("rnd_cmp_a", 32'(a_w[0]), 32'(pe[15:8]));
          check("rnd_cmp_b", 32'(b_w[0]), 32'(pe[7:0]));
          $display("rnd dut0 A=%02h B=%02h res=%b", a_w[0], b_w[0], res_w[0]);
        end
      end
      pend = out_valid_w[0] && !out_ready_t[0];
    end
    out_ready_t[0] = 1'b0;
    check("rnd_pending_pairs", pq.size(), 0);
    check_cnt(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
